// File: rtl/result_uart_tx.sv
// rtl/result_uart_tx.sv - four-word result serializer onto one UART line
// Optional build macro: PARITY_EN (adds an even-parity bit to every frame).
module result_uart_tx #(
    parameter int RES_W        = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [RES_W-1:0] res0_i,
    input  logic [RES_W-1:0] res1_i,
    input  logic [RES_W-1:0] res2_i,
    input  logic [RES_W-1:0] res3_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             drop_o
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t              state_q, state_d;
    logic [BAUD_W-1:0]   baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [1:0]          idx_q, idx_d;
    logic [31:0]         hold_q, hold_d;
    logic                tx_q, tx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                drop_q, drop_d;
    logic                wrap;
    logic [7:0]          cur_byte;

    // Only the low byte of each result word is sent; wider bits are sunk here.
    generate
        if (RES_W > 8) begin : g_wide
            logic unused_hi;
            assign unused_hi = ^{res0_i[RES_W-1:8], res1_i[RES_W-1:8],
                                 res2_i[RES_W-1:8], res3_i[RES_W-1:8]};
        end
    endgenerate

    assign wrap = (baud_q == BAUD_LAST);

    // State register plus all datapath/output flops; reset abandons any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            hold_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state: accept a load in IDLE, otherwise step bits on each baud wrap.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        if (state_q == S_IDLE) begin
            if (load_i) begin
                hold_d  = {res3_i[7:0], res2_i[7:0], res1_i[7:0], res0_i[7:0]};
                baud_d  = '0;
                bit_d   = '0;
                idx_d   = '0;
                state_d = S_START;
            end
        end else begin
            baud_d = wrap ? '0 : baud_q + 1'b1;
            if (wrap) begin
                case (state_q)
                    S_START: begin
                        bit_d   = '0;
                        state_d = S_DATA;
                    end
                    S_DATA: begin
                        if (bit_q == 3'd7) begin
`ifdef PARITY_EN
                            state_d = S_PARITY;
`else
                            state_d = S_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end
`ifdef PARITY_EN
                    S_PARITY: state_d = S_STOP;
`endif
                    S_STOP: begin
                        if (idx_q != 2'd3) begin
                            idx_d   = idx_q + 2'd1;
                            state_d = S_START;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        cur_byte = hold_d[{idx_d, 3'b000} +: 8];
        tx_d     = 1'b1;
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = cur_byte[bit_d];
`ifdef PARITY_EN
            S_PARITY: tx_d = ^cur_byte;
`endif
            default:  tx_d = 1'b1;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_q == S_STOP) && wrap && (idx_q == 2'd3);
        drop_d = load_i && busy_q;
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign drop_o = drop_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// tb/tb_result_uart_tx.sv - table-driven scoreboard bench for result_uart_tx
module tb_result_uart_tx;

    localparam int CPB = 4;
`ifdef PARITY_EN
    localparam int FBITS = 11;
`else
    localparam int FBITS = 10;
`endif
    localparam int BURST = 4 * FBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load_i = 1'b0;
    logic [7:0] res0_i = '0, res1_i = '0, res2_i = '0, res3_i = '0;
    logic       tx_o, busy_o, done_o, drop_o;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int drop_cnt = 0;
    logic [7:0] sb[$];

    result_uart_tx #(.RES_W(8), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .load_i(load_i),
        .res0_i(res0_i), .res1_i(res1_i), .res2_i(res2_i), .res3_i(res3_i),
        .tx_o(tx_o), .busy_o(busy_o), .done_o(done_o), .drop_o(drop_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART decoder: samples mid-bit on the falling clock edge, pops the scoreboard per frame
    logic       d_active = 1'b0;
    int         d_cnt = 0;
    int         pos;
    logic [7:0] d_byte = '0;
    logic [7:0] d_exp;
    always @(negedge clk) begin
        if (done_o) done_cnt++;
        if (drop_o) drop_cnt++;
        if (rst) begin
            d_active = 1'b0;
        end else if (!d_active) begin
            if (tx_o == 1'b0) begin
                d_active = 1'b1;
                d_cnt = 0;
            end
        end else begin
            d_cnt++;
            if (d_cnt % CPB == CPB / 2) begin
                pos = d_cnt / CPB;
                if (pos == 0) begin
                    chk("start_bit", {31'b0, tx_o}, 32'h0);
                end else if (pos <= 8) begin
                    d_byte[pos-1] = tx_o;
                end else if (pos < FBITS - 1) begin
                    chk("parity_bit", {31'b0, tx_o}, {31'b0, ^d_byte});
                end else begin
                    chk("stop_bit", {31'b0, tx_o}, 32'h1);
                    if (sb.size() == 0) begin
                        chk("unexpected_frame", {24'b0, d_byte}, 32'hFFFF_FFFF);
                    end else begin
                        d_exp = sb.pop_front();
                        chk("rx_byte", {24'b0, d_byte}, {24'b0, d_exp});
                    end
                    d_active = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic [7:0] b0, b1, b2, b3;
        int         drop_at;
        bit         b2b;
    } vec_t;

    vec_t vecs[4];

    // Starts a burst from the current post-edge point and runs it to completion.
    task automatic run_burst(input vec_t v);
        int n;
        int dc0, dr0;
        load_i = 1'b1;
        res0_i = v.b0; res1_i = v.b1; res2_i = v.b2; res3_i = v.b3;
        sb.push_back(v.b0); sb.push_back(v.b1); sb.push_back(v.b2); sb.push_back(v.b3);
        @(posedge clk); #1;
        load_i = 1'b0;
        dc0 = done_cnt;
        dr0 = drop_cnt;
        chk("accept_busy", {31'b0, busy_o}, 32'h1);
        chk("accept_tx_low", {31'b0, tx_o}, 32'h0);
        n = 0;
        while (busy_o && n < 2000) begin
            n++;
            if (n == v.drop_at) begin
                load_i = 1'b1;
                res0_i = 8'h11; res1_i = 8'h11; res2_i = 8'h11; res3_i = 8'h11;
            end
            @(posedge clk); #1;
            if (n == v.drop_at) load_i = 1'b0;
        end
        chk("busy_len", n, BURST);
        chk("done_at_busy_fall", {31'b0, done_o}, 32'h1);
        chk("no_early_done", done_cnt - dc0, 0);
        chk("drop_pulses", drop_cnt - dr0, (v.drop_at > 0) ? 1 : 0);
        chk("sb_drained", sb.size(), 0);
    endtask

    initial begin
        int bad;
        vec_t v;
        vecs[0] = '{b0: 8'h55, b1: 8'hA3, b2: 8'h00, b3: 8'hFF, drop_at: 0,  b2b: 1'b0};
        vecs[1] = '{b0: 8'h55, b1: 8'hA3, b2: 8'h00, b3: 8'hFF, drop_at: 20, b2b: 1'b0};
        vecs[2] = '{b0: 8'h01, b1: 8'h02, b2: 8'h03, b3: 8'h04, drop_at: 0,  b2b: 1'b1};
        vecs[3] = '{b0: 8'h3C, b1: 8'hC3, b2: 8'h81, b3: 8'h7E, drop_at: 0,  b2b: 1'b0};

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_tx", {31'b0, tx_o}, 32'h1);
        chk("rst_busy", {31'b0, busy_o}, 32'h0);
        chk("rst_done", {31'b0, done_o}, 32'h0);
        chk("rst_drop", {31'b0, drop_o}, 32'h0);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
        end
        chk("idle_50", bad, 0);

        for (int i = 0; i < 4; i++) begin
            if (!vecs[i].b2b) begin
                repeat (5) @(posedge clk);
                #1;
                chk("pre_idle_tx", {31'b0, tx_o}, 32'h1);
            end else begin
                chk("b2b_idle_tx", {31'b0, tx_o}, 32'h1);
                chk("b2b_in_done", {31'b0, done_o}, 32'h1);
            end
            run_burst(vecs[i]);
        end
        res0_i = '0; res1_i = '0; res2_i = '0; res3_i = '0;

        // Reset mid-frame during the second word's data bits.
        repeat (3) @(posedge clk);
        #1;
        load_i = 1'b1;
        res0_i = 8'hDE; res1_i = 8'hAD; res2_i = 8'hBE; res3_i = 8'hEF;
        sb.push_back(8'hDE); sb.push_back(8'hAD); sb.push_back(8'hBE); sb.push_back(8'hEF);
        @(posedge clk); #1;
        load_i = 1'b0;
        repeat (55) @(posedge clk);
        #1;
        chk("mid_busy", {31'b0, busy_o}, 32'h1);
        rst = 1'b1;
        sb.delete();
        begin
            int dc;
            dc = done_cnt;
            @(posedge clk); #1;
            rst = 1'b0;
            chk("mid_rst_tx", {31'b0, tx_o}, 32'h1);
            chk("mid_rst_busy", {31'b0, busy_o}, 32'h0);
            chk("mid_rst_done", {31'b0, done_o}, 32'h0);
            repeat (10) @(posedge clk);
            #1;
            chk("mid_rst_no_done", done_cnt - dc, 0);
            chk("mid_rst_idle_tx", {31'b0, tx_o}, 32'h1);
        end

        // Load and reset together: reset wins.
        rst = 1'b1;
        load_i = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        load_i = 1'b0;
        @(posedge clk); #1;
        chk("rst_load_busy", {31'b0, busy_o}, 32'h0);
        chk("rst_load_tx", {31'b0, tx_o}, 32'h1);

        v = '{b0: 8'h9A, b1: 8'h5B, b2: 8'hE7, b3: 8'h42, drop_at: 0, b2b: 1'b0};
        run_burst(v);

        repeat (10) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

Serial transmitter for the systolic array's four matrix-multiplier result words, carrying data from the chip back to a host. The keypad scanner and input buffer bring operands in; this block latches result0..result3 on a load pulse and sends them as four back-to-back UART frames on one line. It sits beside the seven-segment drivers at the top level and is driven by the multiplier's result-valid strobe.

## Interface
- RES_W, 8: width of each result word; only bits [7:0] are transmitted, and RES_W must be >= 8.
- CLKS_PER_BIT, 16: clk cycles per serial bit; must be >= 2.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  one-cycle request to capture res0..res3 and start sending.
- res0, res1, res2, res3  in  RES_W each  result words, captured only when a load is accepted.
- tx  out  1  serial line; idle level is high.
- busy  out  1  high from an accepted load until the last stop bit completes.
- done  out  1  one-cycle pulse when the fourth frame's stop bit completes.
- drop  out  1  one-cycle pulse when a load arrives while busy.

## Operation
- Reset values: tx=1, busy=0, done=0, drop=0, state=IDLE. All counters and the word index are cleared.
- A load is accepted when load=1 and busy=0.
  - On acceptance, res0..res3[7:0] are captured into a 4×8 holding register.
  - The word index, bit counter and baud counter are cleared.
  - The state moves to START.
- A load while busy=1 is ignored. The holding register is unchanged, drop pulses for that cycle, and transmission continues undisturbed.
- State machine:
  - IDLE: tx=1. An accepted load moves to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: drives the current word's bits LSB first, bit k for CLKS_PER_BIT cycles each. After bit 7 it moves to PARITY if PARITY_EN is defined, otherwise to STOP.
  - PARITY: tx=even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At the end of STOP:
    - if word index < 3: increment the index and go to START with no idle gap;
    - else: go to IDLE, drive busy=0 and pulse done.
- Words are sent in order res0, res1, res2, res3.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps. The bit-state advances on the wrap cycle.
- Reset mid-frame: the frame is abandoned immediately, tx returns to 1 on the next edge, and no done pulse is issued.
- load and rst asserted together: rst wins and the load is discarded.

## Timing
- Every output is registered.
- tx falls in the first cycle after the edge that accepts the load; busy rises at the same edge.
- Each bit holds for exactly CLKS_PER_BIT cycles.
- Frame length is F = 10 bits, or 11 with PARITY_EN.
- Total busy time is 4·F·CLKS_PER_BIT cycles.
- done and the falling edge of busy occur in the same cycle, immediately after the last stop-bit cycle.
- A load in the cycle where busy=0 (including the cycle in which done is high) is accepted. The next start bit then begins one cycle after that, with exactly one idle tx=1 cycle between bursts.

## Configuration
- PARITY_EN defined: each frame is start, 8 data, even parity, stop, giving 11 bits.
- PARITY_EN undefined: each frame is start, 8 data, stop, giving 10 bits. No parity logic is synthesized.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Reset check: assert rst for 3 cycles -> tx=1, busy=0, done=0, drop=0; tx stays 1 for 50 idle cycles.
- Single burst, no parity: load with res0..3 = 0x55, 0xA3, 0x00, 0xFF -> a UART decoder recovers 55, A3, 00, FF in order. busy is high for exactly 160 cycles; done pulses once, in the cycle busy falls.
- PARITY_EN build, same data -> parity bits 0, 0, 0, 0 (each word has an even number of ones). busy lasts 176 cycles.
- Load while busy: issue a second load with 0x11 at cycle 20 of a burst -> drop pulses for one cycle and the original four bytes are sent unchanged.
- Back-to-back bursts: load again in the done cycle with 0x01..0x04 -> exactly one tx=1 idle cycle, then bytes 01, 02, 03, 04.
- Reset mid-frame: assert rst during DATA of the second word -> tx=1 and busy=0 on the next edge, with no done pulse. A subsequent load sends a complete fresh burst.
